// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: N-direction traffic-light controller.
// Phases GREEN -> YELLOW -> ALLRED are timed in external ticks. Green is handed
// round-robin to the next direction with demand, starting after the current owner.
module traffic_ctrl_multi #(
    parameter int N_DIR       = 4,
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 10,
    parameter int T_GREEN_MAX = 30,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic [N_DIR-1:0]           sensor,
    output logic [2*N_DIR-1:0]         light,
    output logic [$clog2(N_DIR)-1:0]   active_dir,
    output logic [1:0]                 phase
);

    localparam int DIR_W = $clog2(N_DIR);

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        ALLRED = 2'b10
    } phase_e;

    // Comparison constants are one bit wider than the counter so cnt+1 never wraps.
    localparam logic [CNT_W:0]       GREEN_MIN  = (CNT_W+1)'(T_GREEN_MIN);
    localparam logic [CNT_W:0]       GREEN_MAX  = (CNT_W+1)'(T_GREEN_MAX);
    localparam logic [CNT_W:0]       YELLOW_LEN = (CNT_W+1)'(T_YELLOW);
    localparam logic [CNT_W:0]       ALLRED_LEN = (CNT_W+1)'(T_ALLRED);
    localparam logic [CNT_W-1:0]     GREEN_SAT  = CNT_W'(T_GREEN_MAX);
    localparam logic [2*N_DIR-1:0]   LIGHT_RST  = (2*N_DIR)'(2'b10);

    phase_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W:0]       cnt_inc;
    logic [DIR_W-1:0]     dir_q, dir_d, dir_next;
    logic [2*N_DIR-1:0]   light_q, light_d;
    logic                 other_req;

    // Round-robin search for the next requester; finding one is exactly "someone else wants green".
    always_comb begin
        other_req = 1'b0;
        dir_next  = DIR_W'((int'(dir_q) + 1) % N_DIR);
        for (int k = N_DIR - 1; k >= 1; k--) begin
            if (sensor[(int'(dir_q) + k) % N_DIR]) begin
                other_req = 1'b1;
                dir_next  = DIR_W'((int'(dir_q) + k) % N_DIR);
            end
        end
    end

    // Phase, counter and owner registers; lamps are registered alongside so all outputs move together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= GREEN;
            cnt_q   <= '0;
            dir_q   <= '0;
            light_q <= LIGHT_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            light_q <= light_d;
        end
    end

    // Next-state logic: nothing advances without a tick; every phase change clears the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
        if (tick) begin
            case (state_q)
                GREEN: begin
                    if (other_req && ((cnt_inc >= GREEN_MIN && !sensor[dir_q]) ||
                                      cnt_inc >= GREEN_MAX)) begin
                        state_d = YELLOW;
                        cnt_d   = '0;
                    end else if (cnt_inc >= GREEN_MAX) begin
                        cnt_d   = GREEN_SAT;
                    end else begin
                        cnt_d   = cnt_inc[CNT_W-1:0];
                    end
                end
                YELLOW: begin
                    if (cnt_inc == YELLOW_LEN) begin
                        cnt_d = '0;
                        if (T_ALLRED == 0) begin
                            state_d = GREEN;
                            dir_d   = dir_next;
                        end else begin
                            state_d = ALLRED;
                        end
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
                ALLRED: begin
                    if (cnt_inc == ALLRED_LEN) begin
                        state_d = GREEN;
                        dir_d   = dir_next;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
                default: begin
                    state_d = GREEN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Lamp codes derived from the upcoming phase/owner: only the owner is lit, never with 11.
    always_comb begin
        light_d = '0;
        for (int i = 0; i < N_DIR; i++) begin
            if (dir_d == DIR_W'(i)) begin
                if (state_d == GREEN) begin
                    light_d[2*i +: 2] = 2'b10;
                end else if (state_d == YELLOW) begin
                    light_d[2*i +: 2] = 2'b01;
                end
            end
        end
    end

    assign light      = light_q;
    assign active_dir = dir_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi with N_DIR=4, green 4..8, yellow 2, all-red 1.
// Edge numbers count rising edges after reset release; outputs are sampled 1 time unit after each edge.
module tb_traffic_ctrl_multi;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       tick   = 1'b0;
    logic [3:0] sensor = 4'b0000;
    logic [7:0] light;
    logic [1:0] active_dir;
    logic [1:0] phase;

    int checks = 0;
    int errors = 0;

    traffic_ctrl_multi #(
        .N_DIR      (4),
        .CNT_W      (8),
        .T_GREEN_MIN(4),
        .T_GREEN_MAX(8),
        .T_YELLOW   (2),
        .T_ALLRED   (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .sensor    (sensor),
        .light     (light),
        .active_dir(active_dir),
        .phase     (phase)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Safety invariant on every falling edge: no 11 lamp code, at most one direction non-red.
    always @(negedge clk) begin
        int nonRed;
        logic bad;
        nonRed = 0;
        bad    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (light[2*i +: 2] === 2'b11) bad = 1'b1;
            if (light[2*i +: 2] !== 2'b00) nonRed++;
        end
        checks++;
        if (bad || nonRed > 1) begin
            errors++;
            $display("[TB] FAIL lamp_safety at %0t: light=%b, want no 11 and <=1 non-red", $time, light);
        end
    end

    // Expected {light, phase, active_dir} for a given phase and owner.
    function automatic logic [11:0] expVec(input logic [1:0] ph, input int dir);
        logic [7:0] l;
        l = 8'h00;
        if (ph == 2'b00) l[2*dir +: 2] = 2'b10;
        else if (ph == 2'b01) l[2*dir +: 2] = 2'b01;
        return {l, ph, 2'(dir)};
    endfunction

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input logic [3:0] s, input logic t);
        reset  = 1'b1;
        sensor = s;
        tick   = t;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        doReset(4'b0000, 1'b1);
        exp = expVec(2'b00, 0);
        for (int e = 1; e <= 50; e++) begin
            nextEdge();
            checks++;
            if ({light, phase, active_dir} !== exp) begin
                errors++;
                $display("[TB] FAIL reset_idle edge %0d: got %h want %h", e, {light, phase, active_dir}, exp);
            end
        end
    endtask

    task automatic test_single_request();
        logic [11:0] exp;
        doReset(4'b0100, 1'b1);
        for (int e = 1; e <= 20; e++) begin
            nextEdge();
            if (e < 4)      exp = expVec(2'b00, 0);
            else if (e < 6) exp = expVec(2'b01, 0);
            else if (e < 7) exp = expVec(2'b10, 0);
            else            exp = expVec(2'b00, 2);
            checks++;
            if ({light, phase, active_dir} !== exp) begin
                errors++;
                $display("[TB] FAIL single_request edge %0d: got %h want %h", e, {light, phase, active_dir}, exp);
            end
        end
    endtask

    task automatic test_max_green();
        logic [11:0] exp;
        doReset(4'b0011, 1'b1);
        for (int e = 1; e <= 14; e++) begin
            nextEdge();
            if (e < 8)       exp = expVec(2'b00, 0);
            else if (e < 10) exp = expVec(2'b01, 0);
            else if (e < 11) exp = expVec(2'b10, 0);
            else             exp = expVec(2'b00, 1);
            checks++;
            if ({light, phase, active_dir} !== exp) begin
                errors++;
                $display("[TB] FAIL max_green edge %0d: got %h want %h", e, {light, phase, active_dir}, exp);
            end
        end
    endtask

    task automatic test_wrap_skip(input logic withdraw);
        logic [11:0] exp;
        doReset(4'b1000, 1'b1);
        for (int e = 1; e <= 14; e++) begin
            nextEdge();
            if (e < 4)       exp = expVec(2'b00, 0);
            else if (e < 6)  exp = expVec(2'b01, 0);
            else if (e < 7)  exp = expVec(2'b10, 0);
            else if (e < 11) exp = expVec(2'b00, 3);
            else if (e < 13) exp = expVec(2'b01, 3);
            else if (e < 14) exp = expVec(2'b10, 3);
            else             exp = expVec(2'b00, withdraw ? 0 : 1);
            checks++;
            if ({light, phase, active_dir} !== exp) begin
                errors++;
                $display("[TB] FAIL wrap_skip(withdraw=%0b) edge %0d: got %h want %h",
                         withdraw, e, {light, phase, active_dir}, exp);
            end
            if (e == 7) sensor = 4'b0010;
            if (e == 11 && withdraw) sensor = 4'b0000;
        end
    endtask

    task automatic test_slow_tick();
        logic [11:0] exp;
        int t;
        doReset(4'b0100, 1'b0);
        for (int e = 1; e <= 24; e++) begin
            tick = (e % 3 == 0);
            nextEdge();
            t = e / 3;
            if (t < 4)      exp = expVec(2'b00, 0);
            else if (t < 6) exp = expVec(2'b01, 0);
            else if (t < 7) exp = expVec(2'b10, 0);
            else            exp = expVec(2'b00, 2);
            checks++;
            if ({light, phase, active_dir} !== exp) begin
                errors++;
                $display("[TB] FAIL slow_tick edge %0d: got %h want %h", e, {light, phase, active_dir}, exp);
            end
        end
        tick = 1'b1;
    endtask

    task automatic test_reset_midphase();
        logic [11:0] exp;
        doReset(4'b0100, 1'b1);
        for (int e = 1; e <= 5; e++) begin
            nextEdge();
            exp = (e < 4) ? expVec(2'b00, 0) : expVec(2'b01, 0);
            checks++;
            if ({light, phase, active_dir} !== exp) begin
                errors++;
                $display("[TB] FAIL midphase_pre edge %0d: got %h want %h", e, {light, phase, active_dir}, exp);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        exp = expVec(2'b00, 0);
        checks++;
        if ({light, phase, active_dir} !== exp) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h want %h", {light, phase, active_dir}, exp);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            nextEdge();
            if (e < 4)      exp = expVec(2'b00, 0);
            else if (e < 6) exp = expVec(2'b01, 0);
            else if (e < 7) exp = expVec(2'b10, 0);
            else            exp = expVec(2'b00, 2);
            checks++;
            if ({light, phase, active_dir} !== exp) begin
                errors++;
                $display("[TB] FAIL midphase_resume edge %0d: got %h want %h", e, {light, phase, active_dir}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_max_green();
        test_wrap_skip(1'b0);
        test_wrap_skip(1'b1);
        test_slow_tick();
        test_reset_midphase();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_multi.md
# traffic_ctrl_multi

Parametrised N-direction traffic-light controller with timed phases, per-direction vehicle sensors and round-robin arbitration among requesting directions. It generalises the two-street sensor-driven controller: configurable direction count, minimum/maximum green, yellow and all-red clearance times, all counted on an external timebase tick. It sits between the sensor-input synchronisers and the lamp-driver logic.

## Interface
- N_DIR, 4: number of directions; 2..16.
- CNT_W, 8: phase counter width; must satisfy 2^CNT_W > T_GREEN_MAX.
- T_GREEN_MIN, 10: minimum green, in ticks; >= 1.
- T_GREEN_MAX, 30: maximum green under competing demand, in ticks; >= T_GREEN_MIN.
- T_YELLOW, 3: yellow duration, in ticks; >= 1.
- T_ALLRED, 1: all-red clearance, in ticks; 0 means the ALLRED phase is skipped.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  timebase enable; one-cycle pulse per time unit.
- sensor  in  N_DIR  vehicle demand per direction, level, already synchronised.
- light  out  2*N_DIR  lamp code per direction, light[2i+1:2i]: 00 red, 01 yellow, 10 green; 11 never driven.
- active_dir  out  clog2(N_DIR)  direction currently owning green/yellow.
- phase  out  2  00 GREEN, 01 YELLOW, 10 ALLRED.

## Operation
- FSM states GREEN, YELLOW, ALLRED; counter cnt (CNT_W bits) counts ticks since phase entry; cleared on every phase transition.
- All outputs are registered, updated on the same edge as the state.
- Reset values: phase = GREEN, active_dir = 0, cnt = 0, light = direction 0 green (10), all others red (00).
- other_req = OR of sensor over every direction except active_dir.
- GREEN: the active direction shows 10; all others show 00. On a tick, n = cnt+1.
  - Go to YELLOW if other_req and ((n >= T_GREEN_MIN and !sensor[active_dir]) or n >= T_GREEN_MAX).
  - Otherwise cnt <= min(n, T_GREEN_MAX). cnt saturates, so green persists indefinitely while other_req = 0.
- YELLOW: the active direction shows 01. On the tick where cnt+1 = T_YELLOW, go to ALLRED. If T_ALLRED = 0, go directly to GREEN of the next direction.
- ALLRED: all directions show 00. On the tick where cnt+1 = T_ALLRED, go to GREEN of the next direction.
- Next direction: the first index j searched in order active+1, active+2, ... (mod N_DIR, excluding active) with sensor[j] = 1, sampled in the transition cycle. If none is requesting (demand withdrawn), use active+1 mod N_DIR.
- The next direction is computed combinationally and latched into active_dir on the transition edge.
- Without a tick, no counter or state change occurs, whatever the sensor inputs do.
- Exactly one direction is non-red outside ALLRED. At no time are two directions non-red.

## Timing
- Phase durations are exact in ticks: YELLOW = T_YELLOW ticks, ALLRED = T_ALLRED ticks, GREEN >= T_GREEN_MIN ticks.
- A tick in the entry cycle itself is not counted; counting starts in the cycle after the transition edge.
- Sensor-to-decision latency: sensors are sampled only in tick cycles, and the decision takes effect on that cycle's edge.
- Reset asserted mid-phase forces the reset values immediately (asynchronously). The first tick after deassertion counts as tick 1 of the direction 0 GREEN phase.
- A sensor change in the same cycle as the deciding tick uses the new value.

## Test plan
Defaults for these tests: N_DIR=4, T_GREEN_MIN=4, T_GREEN_MAX=8, T_YELLOW=2, T_ALLRED=1, tick=1 every cycle.

- Reset, sensor=0000 for 50 cycles -> light=8'b00_00_00_10, phase=00, active_dir=0 throughout.
- sensor=0100 from reset -> the sequence is:
  - edge 4: phase=01, light=8'b00_00_00_01.
  - edge 6: phase=10, light=0.
  - edge 7: active_dir=2, phase=00, light=8'b00_10_00_00.
- sensor=0011 held -> dir0 green until edge 8 (max green), yellow until edge 10, all-red until edge 11, then active_dir=1 green.
- Wrap and skip: reach active_dir=3 green, then sensor=0010 -> after yellow and all-red, active_dir=1 (directions 0 and 2 skipped). With sensor=0000 at that decision instead, active_dir=0.
- tick pulsed every 3rd cycle with sensor=0100 -> every phase length is 3x the tick count, and nothing changes between ticks.
- reset asserted one cycle into YELLOW -> on the same cycle, without waiting for an edge, light=8'b00_00_00_10, phase=00, active_dir=0. Normal sequencing resumes after release.
- Throughout all tests, a checker asserts that no lamp field equals 11 and that at most one direction is non-red.
